decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 28 ++
 rtl/decoder_despread.sv | 61 ++++++
 rtl/decoder.sv | 203 ++++++++++++++++++++
 tb/tb_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Constants shared by the m-sequence line coder: FSM encodings, LFSR definition,
// sync pattern lengths and line symbol codes.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        FRAME = 2'd2,
        DATA  = 2'd3
    } state_t;

    // x^5 + x^2 + 1: a(n+5) = a(n) ^ a(n+2), chip taken from bit 0
    localparam logic [4:0] LFSR_SEED = 5'b00001;
    localparam logic [4:0] LFSR_TAPS = 5'b00101;

    localparam int HEAD_ZEROS   = 8;
    localparam int RESYNC_ZEROS = 7;
    localparam int CW_BITS      = 7;

    localparam logic [1:0] SYM_CHIP1 = 2'b01;
    localparam logic [1:0] SYM_CHIP0 = 2'b11;
    localparam logic [1:0] SYM_IDLE  = 2'b10;

    function automatic logic [4:0] lfsr_next(input logic [4:0] s);
        return {^(s & LFSR_TAPS), s[4:1]};
    endfunction

endpackage

// File: rtl/decoder_despread.sv
// Chip despreader: strips the local m-sequence from each chip and majority-votes
// CHIPS_PER_BIT recovered chips into one bit, presented as a one-cycle strobe.
module decoder_despread
    import decoder_pkg::*;
#(
    parameter int CHIPS_PER_BIT = 31,
    parameter int MAJ_THRESH    = 16
) (
    input  logic clk31,
    input  logic rst_n,
    input  logic restart,
    input  logic chip_vld,
    input  logic chip,
    output logic bit_stb,
    output logic bit_val
);

    localparam int CNT_W = $clog2(CHIPS_PER_BIT + 1);

    logic [4:0]       lfsr;
    logic [CNT_W-1:0] chip_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] ones_tot;
    logic             rec;
    logic             last_chip;

    assign rec       = chip ^ lfsr[0];
    assign ones_tot  = ones_cnt + CNT_W'(rec);
    assign last_chip = (chip_cnt == CNT_W'(CHIPS_PER_BIT - 1));

    // Idle (restart) parks the sequence at the seed so the next active chip
    // lines up with chip 0 of the transmitter's sequence.
    always_ff @(posedge clk31 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            chip_cnt <= '0;
            ones_cnt <= '0;
            bit_stb  <= 1'b0;
            bit_val  <= 1'b0;
        end else begin
            bit_stb <= 1'b0;
            if (restart) begin
                lfsr     <= LFSR_SEED;
                chip_cnt <= '0;
                ones_cnt <= '0;
            end else if (chip_vld) begin
                lfsr <= lfsr_next(lfsr);
                if (last_chip) begin
                    chip_cnt <= '0;
                    ones_cnt <= '0;
                    bit_stb  <= 1'b1;
                    bit_val  <= (ones_tot >= CNT_W'(MAJ_THRESH));
                end else begin
                    chip_cnt <= chip_cnt + 1'b1;
                    ones_cnt <= ones_tot;
                end
            end
        end
    end

endmodule

// File: rtl/decoder.sv
// Receive decoder: despreads chips into bits, acquires head/frame sync and
// delivers Hamming(7,4)-corrected nibbles with periodic resync checking.
module decoder
    import decoder_pkg::*;
#(
    parameter int CHIPS_PER_BIT   = 31,
    parameter int MAJ_THRESH      = 16,
    parameter int HEAD_ONES       = 10,
    parameter int WORDS_PER_FRAME = 128
) (
    input  logic       clk31,
    input  logic       rst_n,
    input  logic       rx_ena,
    input  logic [1:0] in_data,
    output logic [3:0] out_data,
    output logic       out_valid,
    output logic       err_corrected,
    output logic       frame_lock,
    output logic       sync_lost
);

    localparam int ONES_W = $clog2(HEAD_ONES + 1);
    localparam int ZC_W   = $clog2(HEAD_ZEROS);
    localparam int WC_W   = $clog2(WORDS_PER_FRAME + 1);

    state_t            state, state_nxt;
    logic [ONES_W-1:0] ones_cnt, ones_nxt;
    logic [ZC_W-1:0]   zero_cnt, zeros_nxt;
    logic [2:0]        bit_idx, bit_idx_nxt;
    logic [WC_W-1:0]   word_cnt, word_nxt;
    logic              resync, resync_nxt;
    logic [5:0]        sr, sr_nxt;
    logic              vld_nxt, lost_nxt;
    logic              vld_p0;
    logic [6:0]        cw_p0;
    logic              sym_active, chip_vld, restart;
    logic              bit_stb, bit_val;

    function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
        return {c[2] ^ c[6] ^ c[5] ^ c[4],
                c[1] ^ c[6] ^ c[5] ^ c[3],
                c[0] ^ c[6] ^ c[4] ^ c[3]};
    endfunction

    function automatic logic [3:0] hamming_fix(input logic [6:0] c);
        logic [6:0] flip;
        logic [6:0] fixed;
        case (hamming_syndrome(c))
            3'b111:  flip = 7'b1000000;
            3'b110:  flip = 7'b0100000;
            3'b101:  flip = 7'b0010000;
            3'b011:  flip = 7'b0001000;
            3'b100:  flip = 7'b0000100;
            3'b010:  flip = 7'b0000010;
            3'b001:  flip = 7'b0000001;
            default: flip = 7'b0000000;
        endcase
        fixed = c ^ flip;
        return fixed[6:3];
    endfunction

    // 2'b01 and 2'b11 carry a chip; anything with bit 0 clear is idle
    assign sym_active = in_data[0];
    assign chip_vld   = rx_ena && sym_active;
    assign restart    = !chip_vld;

    decoder_despread #(
        .CHIPS_PER_BIT (CHIPS_PER_BIT),
        .MAJ_THRESH    (MAJ_THRESH)
    ) u_despread (
        .clk31    (clk31),
        .rst_n    (rst_n),
        .restart  (restart),
        .chip_vld (chip_vld),
        .chip     (~in_data[1]),
        .bit_stb  (bit_stb),
        .bit_val  (bit_val)
    );

    always_ff @(posedge clk31 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ones_cnt  <= '0;
            zero_cnt  <= '0;
            bit_idx   <= '0;
            word_cnt  <= '0;
            resync    <= 1'b0;
            vld_p0    <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            ones_cnt  <= ones_nxt;
            zero_cnt  <= zeros_nxt;
            bit_idx   <= bit_idx_nxt;
            word_cnt  <= word_nxt;
            resync    <= resync_nxt;
            vld_p0    <= vld_nxt;
            sync_lost <= lost_nxt;
        end
    end

    always_ff @(posedge clk31) begin
        sr <= sr_nxt;
        if (vld_nxt) cw_p0 <= {sr, bit_val};
    end

    always_comb begin
        state_nxt   = state;
        ones_nxt    = ones_cnt;
        zeros_nxt   = zero_cnt;
        bit_idx_nxt = bit_idx;
        word_nxt    = word_cnt;
        resync_nxt  = resync;
        sr_nxt      = sr;
        vld_nxt     = 1'b0;
        lost_nxt    = 1'b0;
        if (!rx_ena || (!sym_active && state != IDLE)) begin
            lost_nxt    = rx_ena && (state == FRAME || state == DATA);
            state_nxt   = IDLE;
            ones_nxt    = '0;
            zeros_nxt   = '0;
            bit_idx_nxt = '0;
            word_nxt    = '0;
            resync_nxt  = 1'b0;
        end else if (sym_active) begin
            case (state)
                IDLE: state_nxt = HUNT;
                HUNT: if (bit_stb) begin
                    if (bit_val) begin
                        if (ones_cnt != ONES_W'(HEAD_ONES)) ones_nxt = ones_cnt + 1'b1;
                    end else if (ones_cnt >= ONES_W'(HEAD_ONES)) begin
                        state_nxt = FRAME;
                        ones_nxt  = '0;
                        zeros_nxt = ZC_W'(1);
                    end else begin
                        ones_nxt = '0;
                    end
                end
                FRAME: if (bit_stb) begin
                    if (bit_val) begin
                        state_nxt = HUNT;
                        lost_nxt  = 1'b1;
                        ones_nxt  = ONES_W'(1);
                        zeros_nxt = '0;
                    end else if (zero_cnt == ZC_W'(HEAD_ZEROS - 1)) begin
                        state_nxt   = DATA;
                        zeros_nxt   = '0;
                        bit_idx_nxt = '0;
                        word_nxt    = '0;
                        resync_nxt  = 1'b0;
                    end else begin
                        zeros_nxt = zero_cnt + 1'b1;
                    end
                end
                DATA: if (bit_stb) begin
                    if (resync) begin
                        if (bit_val) begin
                            state_nxt  = HUNT;
                            lost_nxt   = 1'b1;
                            ones_nxt   = ONES_W'(1);
                            zeros_nxt  = '0;
                            word_nxt   = '0;
                            resync_nxt = 1'b0;
                        end else if (zero_cnt == ZC_W'(RESYNC_ZEROS - 1)) begin
                            zeros_nxt  = '0;
                            word_nxt   = '0;
                            resync_nxt = 1'b0;
                        end else begin
                            zeros_nxt = zero_cnt + 1'b1;
                        end
                    end else if (bit_idx == 3'(CW_BITS - 1)) begin
                        vld_nxt     = 1'b1;
                        bit_idx_nxt = '0;
                        if (word_cnt == WC_W'(WORDS_PER_FRAME - 1)) resync_nxt = 1'b1;
                        else word_nxt = word_cnt + 1'b1;
                    end else begin
                        sr_nxt      = {sr[4:0], bit_val};
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_lock = (state == FRAME) || (state == DATA);
    end

    // p0 -> output: syndrome correction of the completed codeword
    always_ff @(posedge clk31 or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= 4'h0;
            out_valid     <= 1'b0;
            err_corrected <= 1'b0;
        end else begin
            out_valid     <= vld_p0 && rx_ena;
            err_corrected <= vld_p0 && rx_ena && (hamming_syndrome(cw_p0) != 3'b000);
            if (vld_p0 && rx_ena) out_data <= hamming_fix(cw_p0);
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: chip-level stimulus built from an independent
// m-sequence transmitter model, with hand-computed codewords and outcomes.
module tb_decoder;

    logic       clk31 = 1'b0;
    logic       rst_n;
    logic       rx_ena;
    logic [1:0] in_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       err_corrected;
    logic       frame_lock;
    logic       sync_lost;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] tx_lfsr;
    logic [3:0] vdata [0:511];
    logic       verr  [0:511];
    int         nvalid = 0;
    int         nlost  = 0;
    int         nbad   = 0;
    int         lock_drops = 0;
    logic       lock_watch;

    decoder dut (
        .clk31         (clk31),
        .rst_n         (rst_n),
        .rx_ena        (rx_ena),
        .in_data       (in_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .err_corrected (err_corrected),
        .frame_lock    (frame_lock),
        .sync_lost     (sync_lost)
    );

    always #5 clk31 = ~clk31;

    always @(negedge clk31) begin
        if (out_valid) begin
            vdata[nvalid] = out_data;
            verr[nvalid]  = err_corrected;
            nvalid++;
            if (!frame_lock) nbad++;
        end
        if (sync_lost) nlost++;
        if (lock_watch && !frame_lock) lock_drops++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got still running, want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
    endfunction

    task automatic send_chip(input logic c);
        @(negedge clk31);
        in_data = c ? 2'b01 : 2'b11;
        tx_lfsr = {tx_lfsr[0] ^ tx_lfsr[2], tx_lfsr[4:1]};
    endtask

    task automatic send_bit(input logic b, input int ninv);
        for (int i = 0; i < 31; i++) send_chip(b ^ tx_lfsr[0] ^ (i < ninv));
    endtask

    task automatic send_cw(input logic [6:0] cw);
        for (int i = 6; i >= 0; i--) send_bit(cw[i], 0);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) send_chip(tx_lfsr[0]);
        #1;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk31);
            in_data = 2'b10;
            tx_lfsr = 5'b00001;
        end
    endtask

    task automatic do_reset();
        @(negedge clk31);
        rst_n   = 1'b0;
        rx_ena  = 1'b1;
        in_data = 2'b10;
        tx_lfsr = 5'b00001;
        repeat (3) @(negedge clk31);
        rst_n = 1'b1;
    endtask

    task automatic lock_up();
        do_reset();
        send_idle(2);
        repeat (10) send_bit(1'b1, 0);
        repeat (8) send_bit(1'b0, 0);
    endtask

    task automatic test_reset();
        @(negedge clk31);
        rst_n = 1'b0;
        in_data = 2'b01;
        #1;
        n_checks++; if (out_data !== 4'h0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (err_corrected !== 1'b0) $display("FAIL rst_err: got %b want 0", err_corrected); else n_pass++;
        n_checks++; if (frame_lock !== 1'b0) $display("FAIL rst_lock: got %b want 0", frame_lock); else n_pass++;
        n_checks++; if (sync_lost !== 1'b0) $display("FAIL rst_sync_lost: got %b want 0", sync_lost); else n_pass++;
    endtask

    task automatic test_clean_lock();
        int base, lost0;
        do_reset();
        send_idle(2);
        base = nvalid; lost0 = nlost;
        repeat (10) send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        #1;
        n_checks++; if (frame_lock !== 1'b0) $display("FAIL hunt_lock: got %b want 0", frame_lock); else n_pass++;
        send_bit(1'b0, 0);
        #1;
        n_checks++; if (frame_lock !== 1'b1) $display("FAIL frame_lock_head: got %b want 1", frame_lock); else n_pass++;
        repeat (6) send_bit(1'b0, 0);
        send_cw(7'b1010010);
        pad(5);
        n_checks++; if (nvalid - base !== 1) $display("FAIL clean_count: got %0d want 1", nvalid - base); else n_pass++;
        n_checks++; if (vdata[base] !== 4'hA) $display("FAIL clean_data: got %h want a", vdata[base]); else n_pass++;
        n_checks++; if (verr[base] !== 1'b0) $display("FAIL clean_err: got %b want 0", verr[base]); else n_pass++;
        n_checks++; if (frame_lock !== 1'b1) $display("FAIL clean_lock: got %b want 1", frame_lock); else n_pass++;
        n_checks++; if (nlost - lost0 !== 0) $display("FAIL clean_sync_lost: got %0d want 0", nlost - lost0); else n_pass++;
    endtask

    task automatic test_error_corr();
        int base;
        lock_up();
        base = nvalid;
        send_cw(7'b1000010);
        pad(5);
        n_checks++; if (nvalid - base !== 1) $display("FAIL ecc_count: got %0d want 1", nvalid - base); else n_pass++;
        n_checks++; if (vdata[base] !== 4'hA) $display("FAIL ecc_data: got %h want a", vdata[base]); else n_pass++;
        n_checks++; if (verr[base] !== 1'b1) $display("FAIL ecc_err: got %b want 1", verr[base]); else n_pass++;
    endtask

    task automatic test_noise();
        int base;
        logic [6:0] tail;
        lock_up();
        base = nvalid;
        tail = 7'b1010010;
        send_bit(1'b1, 15);
        for (int i = 5; i >= 0; i--) send_bit(tail[i], 0);
        send_bit(1'b1, 16);
        for (int i = 5; i >= 0; i--) send_bit(tail[i], 0);
        pad(5);
        n_checks++; if (nvalid - base !== 2) $display("FAIL noise_count: got %0d want 2", nvalid - base); else n_pass++;
        n_checks++; if (vdata[base] !== 4'hA) $display("FAIL noise15_data: got %h want a", vdata[base]); else n_pass++;
        n_checks++; if (verr[base] !== 1'b0) $display("FAIL noise15_err: got %b want 0", verr[base]); else n_pass++;
        n_checks++; if (vdata[base+1] !== 4'hA) $display("FAIL noise16_data: got %h want a", vdata[base+1]); else n_pass++;
        n_checks++; if (verr[base+1] !== 1'b1) $display("FAIL noise16_err: got %b want 1", verr[base+1]); else n_pass++;
    endtask

    task automatic test_frame_boundary();
        int base, lost0, bad0, errs;
        lock_up();
        base = nvalid; lost0 = nlost; bad0 = nbad; lock_drops = 0;
        lock_watch = 1'b1;
        for (int i = 0; i < 128; i++) send_cw(enc(4'(i)));
        repeat (7) send_bit(1'b0, 0);
        send_cw(7'b0101101);
        pad(5);
        lock_watch = 1'b0;
        errs = 0;
        for (int i = 0; i < 128; i++)
            if (vdata[base+i] !== 4'(i) || verr[base+i] !== 1'b0) errs++;
        n_checks++; if (nvalid - base !== 129) $display("FAIL frame_count: got %0d want 129", nvalid - base); else n_pass++;
        n_checks++; if (errs !== 0) $display("FAIL frame_words: got %0d bad words want 0", errs); else n_pass++;
        n_checks++; if (vdata[base+128] !== 4'h5) $display("FAIL frame_resync_word: got %h want 5", vdata[base+128]); else n_pass++;
        n_checks++; if (lock_drops !== 0) $display("FAIL frame_lock_held: got %0d low cycles want 0", lock_drops); else n_pass++;
        n_checks++; if (nlost - lost0 !== 0) $display("FAIL frame_sync_lost: got %0d want 0", nlost - lost0); else n_pass++;
        n_checks++; if (nbad - bad0 !== 0) $display("FAIL frame_valid_unlocked: got %0d want 0", nbad - bad0); else n_pass++;
    endtask

    task automatic test_bad_resync();
        int base, lost0;
        lock_up();
        base = nvalid; lost0 = nlost;
        for (int i = 0; i < 128; i++) send_cw(enc(4'(15 - (i % 16))));
        repeat (3) send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        #1;
        n_checks++; if (nlost - lost0 !== 1) $display("FAIL resync_sync_lost: got %0d want 1", nlost - lost0); else n_pass++;
        n_checks++; if (frame_lock !== 1'b0) $display("FAIL resync_lock: got %b want 0", frame_lock); else n_pass++;
        n_checks++; if (nvalid - base !== 128) $display("FAIL resync_count: got %0d want 128", nvalid - base); else n_pass++;
        repeat (9) send_bit(1'b1, 0);
        repeat (8) send_bit(1'b0, 0);
        send_cw(7'b0011110);
        pad(5);
        n_checks++; if (nvalid - base !== 129) $display("FAIL resync_relock_count: got %0d want 129", nvalid - base); else n_pass++;
        n_checks++; if (vdata[base+128] !== 4'h3) $display("FAIL resync_relock_data: got %h want 3", vdata[base+128]); else n_pass++;
    endtask

    task automatic test_abort_idle();
        int base, lost0;
        logic [6:0] cw;
        lock_up();
        base = nvalid; lost0 = nlost;
        send_cw(7'b1010010);
        cw = 7'b1100001;
        for (int i = 6; i >= 4; i--) send_bit(cw[i], 0);
        repeat (10) send_chip(tx_lfsr[0]);
        send_idle(3);
        #1;
        n_checks++; if (nvalid - base !== 1) $display("FAIL idle_abort_count: got %0d want 1", nvalid - base); else n_pass++;
        n_checks++; if (nlost - lost0 !== 1) $display("FAIL idle_abort_sync_lost: got %0d want 1", nlost - lost0); else n_pass++;
        n_checks++; if (frame_lock !== 1'b0) $display("FAIL idle_abort_lock: got %b want 0", frame_lock); else n_pass++;
        repeat (10) send_bit(1'b1, 0);
        repeat (8) send_bit(1'b0, 0);
        send_cw(cw);
        pad(5);
        n_checks++; if (nvalid - base !== 2) $display("FAIL idle_relock_count: got %0d want 2", nvalid - base); else n_pass++;
        n_checks++; if (vdata[base+1] !== 4'hC) $display("FAIL idle_relock_data: got %h want c", vdata[base+1]); else n_pass++;
    endtask

    task automatic test_abort_reset();
        int base, lost0;
        logic [6:0] cw;
        lock_up();
        base = nvalid; lost0 = nlost;
        send_cw(7'b1010010);
        cw = 7'b0110011;
        for (int i = 6; i >= 3; i--) send_bit(cw[i], 0);
        repeat (5) send_chip(tx_lfsr[0]);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_data !== 4'h0) $display("FAIL rstabort_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (frame_lock !== 1'b0) $display("FAIL rstabort_lock: got %b want 0", frame_lock); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstabort_valid: got %b want 0", out_valid); else n_pass++;
        send_idle(3);
        rst_n = 1'b1;
        send_idle(2);
        #1;
        n_checks++; if (nvalid - base !== 1) $display("FAIL rstabort_count: got %0d want 1", nvalid - base); else n_pass++;
        n_checks++; if (nlost - lost0 !== 0) $display("FAIL rstabort_sync_lost: got %0d want 0", nlost - lost0); else n_pass++;
        repeat (10) send_bit(1'b1, 0);
        repeat (8) send_bit(1'b0, 0);
        send_cw(cw);
        pad(5);
        n_checks++; if (nvalid - base !== 2) $display("FAIL rstabort_relock_count: got %0d want 2", nvalid - base); else n_pass++;
        n_checks++; if (vdata[base+1] !== 4'h6) $display("FAIL rstabort_relock_data: got %h want 6", vdata[base+1]); else n_pass++;
    endtask

    task automatic test_rx_disable();
        lock_up();
        @(negedge clk31);
        rx_ena = 1'b0;
        in_data = 2'b01;
        @(negedge clk31);
        #1;
        n_checks++; if (frame_lock !== 1'b0) $display("FAIL rx_disable_lock: got %b want 0", frame_lock); else n_pass++;
        rx_ena = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_ena     = 1'b1;
        in_data    = 2'b10;
        tx_lfsr    = 5'b00001;
        lock_watch = 1'b0;
        test_reset();
        test_clean_lock();
        test_error_corr();
        test_noise();
        test_frame_boundary();
        test_bad_resync();
        test_abort_idle();
        test_abort_reset();
        test_rx_disable();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
